// File: rtl/lc3b_pipe_ctrl.sv
// LC-3b pipeline control: valid bits, stalls, flushes and forwarding selects.
// Optional branch counters are built only when LC3B_PIPE_PERF_EN is defined.
module lc3b_pipe_ctrl #(
  parameter int NUM_STAGES = 5,
  parameter int REG_ADDR_W = 3,
  parameter int RESOLVE_IDX = NUM_STAGES - 3,
  localparam int NREG = NUM_STAGES - 1,
  localparam int SEL_W = $clog2(NREG)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       fetch_valid,
  input  logic                       mem_stall,
  input  logic                       redirect,
  input  logic                       resolve_is_br,
  input  logic [REG_ADDR_W-1:0]      id_src1,
  input  logic [REG_ADDR_W-1:0]      id_src2,
  input  logic                       id_src1_used,
  input  logic                       id_src2_used,
  input  logic [NREG*REG_ADDR_W-1:0] stage_dest,
  input  logic [NREG-1:0]            stage_wr,
  input  logic [NREG-1:0]            stage_is_load,
  output logic [NREG-1:0]            stage_load,
  output logic [NREG-1:0]            stage_valid,
  output logic                       pc_hold,
  output logic [SEL_W-1:0]           fwd_sel1,
  output logic [SEL_W-1:0]           fwd_sel2,
  output logic [15:0]                br_count,
  output logic [15:0]                br_mispredict_count
);

  logic [NREG-1:0] v_q;
  logic [NREG-1:0] v_d;
  logic            load_use;
  logic            redir_eff;
  logic [REG_ADDR_W-1:0] dest1;

  assign dest1     = stage_dest[REG_ADDR_W +: REG_ADDR_W];
  assign redir_eff = redirect && v_q[RESOLVE_IDX];
  assign stage_valid = v_q;

  // Load in register 1 feeding a source the ID instruction reads.
  always_comb begin
    load_use = 1'b0;
    if (v_q[1] && stage_is_load[1] && stage_wr[1]) begin
      if (id_src1_used && dest1 == id_src1)
        load_use = 1'b1;
      if (id_src2_used && dest1 == id_src2)
        load_use = 1'b1;
    end
  end

  // Next valid bits: stall holds, redirect flushes, load-use bubbles.
  always_comb begin
    v_d = v_q;
    if (!mem_stall) begin
      v_d = {v_q[NREG-2:0], fetch_valid};
      if (redir_eff) begin
        for (int k = 0; k <= RESOLVE_IDX; k++)
          v_d[k] = 1'b0;
      end else if (load_use) begin
        v_d[0] = v_q[0];
        v_d[1] = 1'b0;
      end
    end
  end

  // Valid-bit register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      v_q <= '0;
    else
      v_q <= v_d;
  end

  // Buffer load enables and PC hold.
  always_comb begin
    stage_load = '1;
    pc_hold    = 1'b0;
    if (!rst_n || mem_stall) begin
      stage_load = '0;
      pc_hold    = 1'b1;
    end else if (redir_eff) begin
      stage_load = '1;
      pc_hold    = 1'b0;
    end else if (load_use) begin
      stage_load[0] = 1'b0;
      pc_hold       = 1'b1;
    end
  end

  // Youngest matching producer wins; a load in register 1 never forwards.
  always_comb begin
    fwd_sel1 = '0;
    fwd_sel2 = '0;
    for (int k = NREG - 1; k >= 1; k--) begin
      if (v_q[k] && stage_wr[k] &&
          !(k == 1 && stage_is_load[1])) begin
        if (id_src1_used &&
            stage_dest[k*REG_ADDR_W +: REG_ADDR_W] == id_src1)
          fwd_sel1 = SEL_W'(k);
        if (id_src2_used &&
            stage_dest[k*REG_ADDR_W +: REG_ADDR_W] == id_src2)
          fwd_sel2 = SEL_W'(k);
      end
    end
  end

  logic unused_bits;
  assign unused_bits = ^{stage_dest[REG_ADDR_W-1:0],
                         stage_wr[0], stage_is_load};

`ifdef LC3B_PIPE_PERF_EN
  logic [15:0] br_q;
  logic [15:0] mis_q;
  logic        br_ev;

  assign br_ev = !mem_stall && v_q[RESOLVE_IDX] && resolve_is_br;

  // Branch and mispredict counters, wrapping at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_q  <= '0;
      mis_q <= '0;
    end else if (br_ev) begin
      br_q <= br_q + 16'd1;
      if (redirect)
        mis_q <= mis_q + 16'd1;
    end
  end

  assign br_count            = br_q;
  assign br_mispredict_count = mis_q;
`else
  logic unused_perf;
  assign unused_perf = resolve_is_br;
  assign br_count            = 16'h0000;
  assign br_mispredict_count = 16'h0000;
`endif

endmodule

// File: tb/tb_lc3b_pipe_ctrl.sv
// Testbench for lc3b_pipe_ctrl at default depth 5.
// Compares against a cycle-level model of valid bits and counters.
module tb_lc3b_pipe_ctrl;

  localparam int NREG = 4;
  localparam int AW   = 3;
  localparam int RES  = 2;
`ifdef LC3B_PIPE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic fetch_valid, mem_stall, redirect, resolve_is_br;
  logic [AW-1:0] id_src1, id_src2;
  logic id_src1_used, id_src2_used;
  logic [NREG*AW-1:0] stage_dest;
  logic [NREG-1:0] stage_wr, stage_is_load;
  logic [NREG-1:0] stage_load, stage_valid;
  logic pc_hold;
  logic [1:0] fwd_sel1, fwd_sel2;
  logic [15:0] br_count, br_mispredict_count;

  lc3b_pipe_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_valid(fetch_valid), .mem_stall(mem_stall),
    .redirect(redirect), .resolve_is_br(resolve_is_br),
    .id_src1(id_src1), .id_src2(id_src2),
    .id_src1_used(id_src1_used), .id_src2_used(id_src2_used),
    .stage_dest(stage_dest), .stage_wr(stage_wr),
    .stage_is_load(stage_is_load),
    .stage_load(stage_load), .stage_valid(stage_valid),
    .pc_hold(pc_hold),
    .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2),
    .br_count(br_count),
    .br_mispredict_count(br_mispredict_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [NREG-1:0] mv;
  logic [15:0] mbr, mmis;

  function automatic logic [AW-1:0] dst(int k);
    return stage_dest[k*AW +: AW];
  endfunction

  function automatic bit m_lu();
    bit hit;
    hit = (id_src1_used && dst(1) == id_src1) ||
          (id_src2_used && dst(1) == id_src2);
    return mv[1] && stage_is_load[1] && stage_wr[1] && hit;
  endfunction

  function automatic bit m_redir();
    return redirect && mv[RES];
  endfunction

  function automatic logic [1:0] m_fwd(input logic [AW-1:0] src,
                                       input logic used);
    if (!used) return 2'd0;
    for (int k = 1; k < NREG; k++)
      if (mv[k] && stage_wr[k] && dst(k) == src &&
          !(k == 1 && stage_is_load[1]))
        return 2'(k);
    return 2'd0;
  endfunction

  function automatic logic [NREG-1:0] m_load();
    if (!rst_n || mem_stall) return '0;
    if (m_redir()) return '1;
    if (m_lu()) return 4'b1110;
    return '1;
  endfunction

  function automatic logic m_hold();
    if (!rst_n || mem_stall) return 1'b1;
    if (m_redir()) return 1'b0;
    return m_lu();
  endfunction

  function automatic logic [15:0] e_br();
    return PERF ? mbr : 16'h0000;
  endfunction

  function automatic logic [15:0] e_mis();
    return PERF ? mmis : 16'h0000;
  endfunction

  task automatic step();
    logic [NREG-1:0] nv;
    logic [15:0] nb, nm;
    nv = mv; nb = mbr; nm = mmis;
    if (!mem_stall) begin
      if (m_redir()) begin
        for (int k = 0; k < NREG; k++)
          if (k <= RES) nv[k] = 1'b0;
          else nv[k] = mv[k-1];
      end else if (m_lu()) begin
        nv[1] = 1'b0;
        for (int k = 2; k < NREG; k++) nv[k] = mv[k-1];
      end else begin
        nv[0] = fetch_valid;
        for (int k = 1; k < NREG; k++) nv[k] = mv[k-1];
      end
      if (mv[RES] && resolve_is_br) begin
        nb = nb + 16'd1;
        if (redirect) nm = nm + 16'd1;
      end
    end
    @(posedge clk);
    mv = nv; mbr = nb; mmis = nm;
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    fetch_valid = 0; mem_stall = 0; redirect = 0;
    resolve_is_br = 0; id_src1 = 0; id_src2 = 0;
    id_src1_used = 0; id_src2_used = 0;
    stage_dest = '0; stage_wr = '0; stage_is_load = '0;
  endtask

  task automatic set_dest(input int k, input logic [AW-1:0] r);
    stage_dest[k*AW +: AW] = r;
  endtask

  task automatic test_reset();
    rst_n = 0;
    clear_inputs();
    mv = '0; mbr = '0; mmis = '0;
    @(negedge clk); #1;
    checks++;
    if (stage_valid !== 4'b0000) begin
      errors++; $display("FAIL reset_valid got %b want 0000", stage_valid);
    end
    checks++;
    if (stage_load !== 4'b0000 || pc_hold !== 1'b1) begin
      errors++;
      $display("FAIL reset_ctrl got load=%b hold=%b want 0000/1",
               stage_load, pc_hold);
    end
    checks++;
    if (br_count !== 16'h0 || br_mispredict_count !== 16'h0) begin
      errors++;
      $display("FAIL reset_cnt got %h/%h want 0/0",
               br_count, br_mispredict_count);
    end
    @(negedge clk);
  endtask

  task automatic test_cold_start();
    rst_n = 1;
    fetch_valid = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (stage_load !== 4'b1111 || stage_load !== m_load()) begin
        errors++; $display("FAIL cold_load got %b want 1111", stage_load);
      end
      step();
    end
    checks++;
    if (stage_valid !== 4'b1111 || stage_valid !== mv) begin
      errors++; $display("FAIL cold_valid got %b want 1111", stage_valid);
    end
  endtask

  task automatic test_load_use();
    stage_is_load = 4'b0010; stage_wr = 4'b0010;
    set_dest(1, 3'd2);
    id_src1 = 3'd2; id_src1_used = 1;
    #1;
    checks++;
    if (stage_load !== 4'b1110 || pc_hold !== 1'b1) begin
      errors++;
      $display("FAIL lu_ctrl got load=%b hold=%b want 1110/1",
               stage_load, pc_hold);
    end
    checks++;
    if (fwd_sel1 !== 2'd0) begin
      errors++; $display("FAIL lu_nofwd got %0d want 0", fwd_sel1);
    end
    step();
    checks++;
    if (stage_valid !== 4'b1101 || stage_valid !== mv) begin
      errors++; $display("FAIL lu_bubble got %b want 1101", stage_valid);
    end
    stage_is_load = 4'b0100; stage_wr = 4'b0100;
    set_dest(1, 3'd0); set_dest(2, 3'd2);
    #1;
    checks++;
    if (fwd_sel1 !== 2'd2 || stage_load !== 4'b1111) begin
      errors++;
      $display("FAIL lu_fwd got sel=%0d load=%b want 2/1111",
               fwd_sel1, stage_load);
    end
  endtask

  task automatic test_forward_priority();
    clear_inputs();
    fetch_valid = 1;
    repeat (4) step();
    stage_wr = 4'b1010;
    set_dest(1, 3'd3); set_dest(3, 3'd3); set_dest(2, 3'd5);
    id_src2 = 3'd3; id_src2_used = 1;
    id_src1 = 3'd5; id_src1_used = 1;
    #1;
    checks++;
    if (fwd_sel2 !== 2'd1 || fwd_sel2 !== m_fwd(id_src2, id_src2_used)) begin
      errors++; $display("FAIL fwd_prio got %0d want 1", fwd_sel2);
    end
    checks++;
    if (fwd_sel1 !== 2'd0) begin
      errors++; $display("FAIL fwd_nowr got %0d want 0", fwd_sel1);
    end
    stage_wr = 4'b1000;
    #1;
    checks++;
    if (fwd_sel2 !== 2'd3) begin
      errors++; $display("FAIL fwd_old got %0d want 3", fwd_sel2);
    end
    stage_wr = 4'b1010;
    id_src2_used = 0;
    #1;
    checks++;
    if (fwd_sel2 !== 2'd0) begin
      errors++; $display("FAIL fwd_unused got %0d want 0", fwd_sel2);
    end
    @(negedge clk);
  endtask

  task automatic test_redirect();
    logic [15:0] b0, m0;
    clear_inputs();
    fetch_valid = 1;
    repeat (4) step();
    stage_is_load = 4'b0010; stage_wr = 4'b0010;
    set_dest(1, 3'd4);
    id_src1 = 3'd4; id_src1_used = 1;
    redirect = 1; resolve_is_br = 1;
    b0 = e_br(); m0 = e_mis();
    #1;
    checks++;
    if (pc_hold !== 1'b0 || stage_load !== 4'b1111) begin
      errors++;
      $display("FAIL redir_ctrl got hold=%b load=%b want 0/1111",
               pc_hold, stage_load);
    end
    step();
    checks++;
    if (stage_valid !== 4'b1000 || stage_valid !== mv) begin
      errors++; $display("FAIL redir_flush got %b want 1000", stage_valid);
    end
    checks++;
    if (br_count !== e_br() ||
        br_count !== (PERF ? b0 + 16'd1 : 16'h0)) begin
      errors++; $display("FAIL redir_br got %h want %h", br_count, e_br());
    end
    checks++;
    if (br_mispredict_count !== e_mis() ||
        br_mispredict_count !== (PERF ? m0 + 16'd1 : 16'h0)) begin
      errors++;
      $display("FAIL redir_mis got %h want %h",
               br_mispredict_count, e_mis());
    end
  endtask

  task automatic test_stall();
    logic [15:0] b0, m0;
    clear_inputs();
    fetch_valid = 1;
    repeat (4) step();
    b0 = e_br(); m0 = e_mis();
    mem_stall = 1; redirect = 1; resolve_is_br = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (stage_load !== 4'b0000 || pc_hold !== 1'b1) begin
        errors++;
        $display("FAIL stall_ctrl got load=%b hold=%b want 0000/1",
                 stage_load, pc_hold);
      end
      step();
      checks++;
      if (stage_valid !== 4'b1111 || br_count !== b0 ||
          br_mispredict_count !== m0) begin
        errors++;
        $display("FAIL stall_hold got v=%b br=%h mis=%h want 1111/%h/%h",
                 stage_valid, br_count, br_mispredict_count, b0, m0);
      end
    end
    mem_stall = 0;
    #1;
    checks++;
    if (pc_hold !== 1'b0) begin
      errors++; $display("FAIL stall_release_hold got %b want 0", pc_hold);
    end
    step();
    checks++;
    if (stage_valid !== 4'b1000 || br_count !== e_br() ||
        br_mispredict_count !== e_mis()) begin
      errors++;
      $display("FAIL stall_release got v=%b br=%h want 1000/%h",
               stage_valid, br_count, e_br());
    end
  endtask

  task automatic test_reset_mid_event();
    clear_inputs();
    fetch_valid = 1;
    repeat (4) step();
    mem_stall = 1; redirect = 1; resolve_is_br = 1;
    @(posedge clk); #2;
    rst_n = 0;
    mv = '0; mbr = '0; mmis = '0;
    #1;
    checks++;
    if (stage_valid !== 4'b0000 || stage_load !== 4'b0000 ||
        br_count !== 16'h0) begin
      errors++;
      $display("FAIL async_reset got v=%b load=%b br=%h want 0/0/0",
               stage_valid, stage_load, br_count);
    end
    @(negedge clk);
    rst_n = 1;
    mem_stall = 0;
    #1;
    checks++;
    if (stage_load !== 4'b1111 || pc_hold !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_ctrl got load=%b hold=%b want 1111/0",
               stage_load, pc_hold);
    end
    step();
    checks++;
    if (stage_valid !== 4'b0001) begin
      errors++; $display("FAIL post_reset_v got %b want 0001", stage_valid);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      fetch_valid   = ($urandom % 4) != 0;
      mem_stall     = ($urandom % 5) == 0;
      redirect      = ($urandom % 4) == 0;
      resolve_is_br = $urandom % 2;
      id_src1       = 3'($urandom % 4);
      id_src2       = 3'($urandom % 4);
      id_src1_used  = $urandom % 2;
      id_src2_used  = $urandom % 2;
      for (int k = 0; k < NREG; k++) set_dest(k, 3'($urandom % 4));
      stage_wr      = 4'($urandom);
      stage_is_load = 4'($urandom);
      #1;
      checks++;
      if (stage_load !== m_load() || pc_hold !== m_hold() ||
          fwd_sel1 !== m_fwd(id_src1, id_src1_used) ||
          fwd_sel2 !== m_fwd(id_src2, id_src2_used) ||
          stage_valid !== mv || br_count !== e_br() ||
          br_mispredict_count !== e_mis()) begin
        errors++;
        $display("FAIL rand[%0d] got ld=%b h=%b f=%0d/%0d v=%b c=%h/%h want ld=%b h=%b f=%0d/%0d v=%b c=%h/%h",
                 i, stage_load, pc_hold, fwd_sel1, fwd_sel2, stage_valid,
                 br_count, br_mispredict_count, m_load(), m_hold(),
                 m_fwd(id_src1, id_src1_used), m_fwd(id_src2, id_src2_used),
                 mv, e_br(), e_mis());
      end
      step();
    end
  endtask

  task automatic test_counter_wrap();
    clear_inputs();
    fetch_valid = 1; resolve_is_br = 1;
    repeat (3) step();
`ifdef LC3B_PIPE_PERF_EN
    while (mbr != 16'hFFFF) step();
    checks++;
    if (br_count !== 16'hFFFF) begin
      errors++; $display("FAIL wrap_pre got %h want ffff", br_count);
    end
    step();
    checks++;
    if (br_count !== 16'h0000 || br_count !== mbr) begin
      errors++; $display("FAIL wrap got %h want 0000", br_count);
    end
`else
    repeat (20) step();
    checks++;
    if (br_count !== 16'h0000 || br_mispredict_count !== 16'h0000) begin
      errors++;
      $display("FAIL perf_off got %h/%h want 0/0",
               br_count, br_mispredict_count);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_cold_start();
    test_load_use();
    test_forward_priority();
    test_redirect();
    test_stall();
    test_reset_mid_event();
    test_random();
    test_counter_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lc3b_pipe_ctrl.md
LC3B_PIPE_CTRL -- requirements
Module: lc3b_pipe_ctrl

Interface
REQ-001 SHALL take parameter NUM_STAGES, default 5: pipeline depth; there are NREG = NUM_STAGES-1 inter-stage registers, indexed 0 (IF/ID) to NREG-1 (MEM/WB); legal range 4..8.
REQ-002 SHALL take parameter REG_ADDR_W, default 3: register-address width.
REQ-003 SHALL take parameter RESOLVE_IDX, default NUM_STAGES-3: index of the register whose contents resolve redirects (EX/MEM at depth 5).
REQ-004 SHALL have these ports (name, direction, width, meaning):
  clk  in  1  sole clock; all state updates on the rising edge
  rst_n  in  1  asynchronous active-low reset
  fetch_valid  in  1  IF presents an instruction this cycle
  mem_stall  in  1  data port busy; freeze the whole pipe
  redirect  in  1  control transfer taken by the instruction in register RESOLVE_IDX
  resolve_is_br  in  1  register RESOLVE_IDX holds a conditional branch
  id_src1, id_src2  in  REG_ADDR_W each  source registers of the instruction in register 0
  id_src1_used, id_src2_used  in  1 each  the source is actually read
  stage_dest  in  NREG*REG_ADDR_W  packed destination register of each register
  stage_wr  in  NREG  register k writes the regfile
  stage_is_load  in  NREG  register k holds an LDR/LDB/LDI
  stage_load  out  NREG  load enable for each pipeline buffer
  stage_valid  out  NREG  register k holds a live instruction
  pc_hold  out  1  IF holds its PC
  fwd_sel1, fwd_sel2  out  clog2(NREG) each  0 = regfile, k = forward from register k
  br_count, br_mispredict_count  out  16 each  performance counters

Function
REQ-005 SHALL keep one valid bit per register; stage_valid[k] presents bit k.
REQ-006 With mem_stall=1: stage_load=0, pc_hold=1, all valid bits hold, counters hold; redirect and load-use are ignored in that cycle.
REQ-007 Normal advance (no stall, no redirect, no load-use): stage_load all ones; v[0] <= fetch_valid; v[k] <= v[k-1].
REQ-008 Load-use hazard exists when v[1]=1, stage_is_load[1]=1, stage_wr[1]=1, and stage_dest[1] equals a used ID source.
REQ-009 On a load-use hazard: stage_load[0]=0, pc_hold=1, v[0] holds, v[1] <= 0 (bubble), registers 2..NREG-1 advance as in REQ-007.
REQ-010 Redirect is effective only when redirect=1 and v[RESOLVE_IDX]=1.
REQ-011 An effective redirect clears v[0..RESOLVE_IDX], and registers above RESOLVE_IDX advance normally.
REQ-012 Redirect SHALL take priority over a load-use hazard in the same cycle; pc_hold=0, so IF loads the target PC.
REQ-013 Forwarding SHALL be combinational: for each used source, fwd_sel = smallest k in 1..NREG-1 with v[k]=1, stage_wr[k]=1 and stage_dest[k] equal to the source; otherwise 0.
REQ-014 An unused source SHALL give fwd_sel=0.
REQ-015 A load in register 1 SHALL never be selected for forwarding; it stalls per REQ-009.
REQ-016 br_count SHALL increment when v[RESOLVE_IDX]=1, resolve_is_br=1 and mem_stall=0.
REQ-017 br_mispredict_count SHALL increment under the REQ-016 condition when redirect=1 (predict-not-taken).
REQ-018 Both counters SHALL wrap from 16'hFFFF to 16'h0000.

Reset
REQ-019 rst_n=0 SHALL immediately clear all valid bits and both counters.
REQ-020 During reset, stage_load SHALL be 0 and pc_hold 1.
REQ-021 Reset asserted mid-stall or mid-redirect SHALL discard that event; the first cycle after release behaves per REQ-007.

Configuration
REQ-022 Macro LC3B_PIPE_PERF_EN defined: counters implemented per REQ-016..018.
REQ-023 Macro LC3B_PIPE_PERF_EN undefined: no counter flops; br_count and br_mispredict_count are tied to 16'h0000; all other behaviour identical.

Verification
REQ-024 Cold start: release reset, fetch_valid=1 for 4 cycles, depth 5 -> stage_valid reaches 4'b1111 on the 4th edge, stage_load=4'b1111 throughout.
REQ-025 Load-use: LDR writing R2 in register 1, id_src1=2 used -> one cycle with stage_load=4'b1110, pc_hold=1, v[1]=0 next; next cycle fwd_sel1=2.
REQ-026 Forward priority: R3 written by registers 1 and 3 (neither a load), id_src2=3 used -> fwd_sel2=1; id_src2_used=0 -> fwd_sel2=0.
REQ-027 Redirect with simultaneous load-use: redirect=1, v[2]=1, resolve_is_br=1 -> v[0..2] cleared, v[3] <= 1, pc_hold=0, br_count +1, br_mispredict_count +1.
REQ-028 Stall: mem_stall=1 for 3 cycles together with redirect=1 -> state and counters unchanged; redirect acts on the cycle mem_stall falls.
REQ-029 Counter wrap and macro: br_count preset at 16'hFFFF, one branch resolves -> 16'h0000; same bench with LC3B_PIPE_PERF_EN undefined -> counters stay 0.
